// File: rtl/led7_pkg.sv
// Shared definitions for the 7-segment display blocks: glyph table,
// blank pattern and segment bit positions.
package led7_pkg;

    // Active-high glyph, bits g..a on [6:0].
    typedef logic [6:0] glyph_t;

    // Bit position of each segment within a glyph.
    typedef enum int {
        SEG_A = 0,
        SEG_B = 1,
        SEG_C = 2,
        SEG_D = 3,
        SEG_E = 4,
        SEG_F = 5,
        SEG_G = 6
    } seg_idx_e;

    // All segments dark at the active-low pins.
    localparam glyph_t SEG_BLANK = 7'h7F;

    // Hex glyphs, entry n is the pattern for nibble value n.
    localparam glyph_t [15:0] GLYPH_TABLE = {
        7'b1110001,  // F
        7'b1111001,  // E
        7'b1011110,  // d
        7'b0111001,  // C
        7'b1111100,  // b
        7'b1110111,  // A
        7'b1101111,  // 9
        7'b1111111,  // 8
        7'b0000111,  // 7
        7'b1111101,  // 6
        7'b1101101,  // 5
        7'b1100110,  // 4
        7'b1001111,  // 3
        7'b1011011,  // 2
        7'b0000110,  // 1
        7'b0111111   // 0
    };

endpackage

// File: rtl/led7_glyph.sv
// Combinational hex nibble to active-high 7-segment glyph decoder.
module led7_glyph
    import led7_pkg::*;
(
    input  logic [3:0] nibble,
    output glyph_t     glyph
);

    // Table lookup; every nibble value has a defined glyph.
    assign glyph = GLYPH_TABLE[nibble];

endmodule

// File: rtl/led7_scan_driver.sv
// Time-multiplexed common-anode 7-segment driver with tear-free shadow
// register, leading-zero blanking and a dark guard interval per slot.
module led7_scan_driver
    import led7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000,
    parameter int GUARD    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp,
    input  logic                  lz_en,
    input  logic                  load,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [DIGITS-1:0]     dig_n,
    output logic                  frame_done
);

    localparam int PC_W = $clog2(SCAN_DIV);
    localparam int DI_W = $clog2(DIGITS);

    localparam logic [PC_W-1:0] PC_LAST  = PC_W'(SCAN_DIV - 1);
    localparam logic [PC_W-1:0] PC_GUARD = PC_W'(GUARD);
    localparam logic [DI_W-1:0] DI_LAST  = DI_W'(DIGITS - 1);

    logic [PC_W-1:0]          pc;
    logic [DI_W-1:0]          di;
    logic                     pc_wrap;
    logic                     boundary;

    logic [DIGITS-1:0][3:0]   staging_val;
    logic [DIGITS-1:0]        staging_dp;
    logic [DIGITS-1:0][3:0]   shadow_val;
    logic [DIGITS-1:0]        shadow_dp;
    logic                     pending;

    logic [DIGITS-1:0]        lz_blank;
    logic                     zero_run;
    glyph_t                   cur_glyph;

    logic [6:0]               seg_nx;
    logic                     dp_nx;
    logic [DIGITS-1:0]        dig_nx;

    assign pc_wrap  = (pc == PC_LAST);
    assign boundary = pc_wrap && (di == DI_LAST);

    // Slot prescaler and digit index; the index steps once per slot.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: registers use non-blocking (<=) so every flop samples the
        // pre-edge values; blocking here would create order-dependent logic.
        if (rst) begin
            pc <= '0;
            di <= '0;
        end else if (pc_wrap) begin
            pc <= '0;
            di <= (di == DI_LAST) ? '0 : di + 1'b1;
        end else begin
            pc <= pc + 1'b1;
        end
    end

    // Load handshake: staging takes every load, shadow only changes at a
    // frame boundary so one frame never mixes old and new digits.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: staging and shadow are plain flop banks, not RAM, so they
        // can and must be reset; a real memory array would be left unreset.
        if (rst) begin
            staging_val <= '0;
            staging_dp  <= '0;
            shadow_val  <= '0;
            shadow_dp   <= '0;
            pending     <= 1'b0;
        end else begin
            // Transfer uses the pre-load staging contents on a coincident load.
            if (boundary && pending) begin
                shadow_val <= staging_val;
                shadow_dp  <= staging_dp;
            end
            if (load) begin
                staging_val <= value;
                staging_dp  <= dp;
                pending     <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
        end
    end

    // Leading-zero mask: digit i blanks when it and all higher nibbles are zero.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path
        // leaves it unassigned, which would otherwise infer a latch.
        lz_blank = '0;
        zero_run = 1'b1;
        for (int i = DIGITS - 1; i > 0; i--) begin
            zero_run    = zero_run & (shadow_val[i] == 4'h0);
            lz_blank[i] = zero_run & lz_en;
        end
    end

    led7_glyph u_glyph (
        .nibble (shadow_val[di]),
        .glyph  (cur_glyph)
    );

    // Next pin values: dark during the guard window, else the current digit.
    always_comb begin
        seg_nx = SEG_BLANK;
        dp_nx  = 1'b1;
        dig_nx = '1;
        if (pc >= PC_GUARD) begin
            dig_nx = ~(DIGITS'(1) << di);
            seg_nx = lz_blank[di] ? SEG_BLANK : ~cur_glyph;
            dp_nx  = ~shadow_dp[di];
        end
    end

    // Registered pins; frame_done follows the boundary cycle by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n      <= SEG_BLANK;
            dp_n       <= 1'b1;
            dig_n      <= '1;
            frame_done <= 1'b0;
        end else begin
            seg_n      <= seg_nx;
            dp_n       <= dp_nx;
            dig_n      <= dig_nx;
            frame_done <= boundary;
        end
    end

endmodule

// File: tb/tb_led7_scan_driver.sv
// Scoreboard bench for led7_scan_driver with DIGITS=4, SCAN_DIV=8, GUARD=2.
module tb_led7_scan_driver;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 8;
    localparam int GUARD    = 2;
    localparam int FRAME    = DIGITS * SCAN_DIV;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic [15:0] value = '0;
    logic [3:0]  dp    = '0;
    logic        lz_en = 1'b0;
    logic        load  = 1'b0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  dig_n;
    logic        frame_done;

    led7_scan_driver #(
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV),
        .GUARD    (GUARD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .value      (value),
        .dp         (dp),
        .lz_en      (lz_en),
        .load       (load),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .dig_n      (dig_n),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dig_n;
        logic [6:0] seg_n;
        logic       dp_n;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected slot contents; glyphs given active-high as in the glyph table.
    task automatic push_exp(input int d, input logic [6:0] glyph_ah, input logic blank, input logic dp_lit);
        exp_t e;
        e.dig_n = ~(4'b0001 << d);
        e.seg_n = blank ? 7'h7F : ~glyph_ah;
        e.dp_n  = ~dp_lit;
        exp_q.push_back(e);
    endtask

    task automatic push_frame(input logic [6:0] g0, input logic [6:0] g1, input logic [6:0] g2,
                              input logic [6:0] g3, input logic [3:0] blank, input logic [3:0] dpl);
        push_exp(0, g0, blank[0], dpl[0]);
        push_exp(1, g1, blank[1], dpl[1]);
        push_exp(2, g2, blank[2], dpl[2]);
        push_exp(3, g3, blank[3], dpl[3]);
    endtask

    task automatic do_load(input logic [15:0] v, input logic [3:0] d);
        @(negedge clk);
        value = v;
        dp    = d;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
    endtask

    // Returns on the negedge where frame_done is seen, bounded to three frames.
    task automatic wait_frame();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (frame_done !== 1'b1 && n < 3 * FRAME);
        check("frame_wait", {31'b0, frame_done}, 32'd1);
    endtask

    // Clock edges since reset release; output after edge k reflects slot
    // position (k-1) mod SCAN_DIV.
    int cyc = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    int         mp;
    int         md;
    logic [3:0] mexp;
    exp_t       me;

    // Monitor: scan pattern and frame pulse every cycle, scoreboard pop at
    // the first lit cycle of each slot.
    always @(negedge clk) begin
        if (!rst && cyc > 0) begin
            mp   = (cyc - 1) % SCAN_DIV;
            md   = ((cyc - 1) / SCAN_DIV) % DIGITS;
            mexp = (mp < GUARD) ? 4'hF : ~(4'b0001 << md);
            check("dig_n_scan", {28'b0, dig_n}, {28'b0, mexp});
            check("frame_done_pulse", {31'b0, frame_done}, {31'b0, (cyc % FRAME) == 0});
            if (mp == GUARD && exp_q.size() > 0) begin
                me = exp_q.pop_front();
                check("slot_dig_n", {28'b0, dig_n}, {28'b0, me.dig_n});
                check("slot_seg_n", {25'b0, seg_n}, {25'b0, me.seg_n});
                check("slot_dp_n",  {31'b0, dp_n},  {31'b0, me.dp_n});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_seg_n", {25'b0, seg_n}, 32'h7F);
        check("rst_dp_n", {31'b0, dp_n}, 32'd1);
        check("rst_dig_n", {28'b0, dig_n}, 32'hF);
        check("rst_frame_done", {31'b0, frame_done}, 32'd0);
        rst = 1'b0;

        // Mid-slot reset while digit 2 is lit.
        repeat (20) @(negedge clk);
        check("pre_rst_dig2", {28'b0, dig_n}, 32'hB);
        #2 rst = 1'b1;
        #1;
        check("midrst_dig_n", {28'b0, dig_n}, 32'hF);
        check("midrst_seg_n", {25'b0, seg_n}, 32'h7F);
        check("midrst_dp_n", {31'b0, dp_n}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_c1", {28'b0, dig_n}, 32'hF);
        @(negedge clk);
        check("post_rst_c2", {28'b0, dig_n}, 32'hF);
        @(negedge clk);
        check("post_rst_c3_dig", {28'b0, dig_n}, 32'hE);
        check("post_rst_c3_seg", {25'b0, seg_n}, 32'h40);

        // 12AF with decimal point on digit 2.
        do_load(16'h12AF, 4'b0100);
        wait_frame();
        push_frame(7'b1110001, 7'b1110111, 7'b1011011, 7'b0000110, 4'b0000, 4'b0100);

        // 1234, then a mid-frame load of 0000 that must wait for the next frame.
        do_load(16'h1234, 4'b0000);
        wait_frame();
        push_frame(7'b1100110, 7'b1001111, 7'b1011011, 7'b0000110, 4'b0000, 4'b0000);
        repeat (12) @(negedge clk);
        do_load(16'h0000, 4'b0000);
        wait_frame();
        push_frame(7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111, 4'b0000, 4'b0000);

        // Leading-zero suppression.
        do_load(16'h0050, 4'b0000);
        wait_frame();
        lz_en = 1'b1;
        push_frame(7'b0111111, 7'b1101101, 7'b0000000, 7'b0000000, 4'b1100, 4'b0000);
        do_load(16'h0000, 4'b1000);
        wait_frame();
        push_frame(7'b0111111, 7'b0000000, 7'b0000000, 7'b0000000, 4'b1110, 4'b1000);

        // Load on the exact boundary cycle.
        do_load(16'h1111, 4'b0000);
        wait_frame();
        lz_en = 1'b0;
        push_frame(7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 4'b0000, 4'b0000);
        repeat (FRAME - 1) @(negedge clk);
        value = 16'hBEEF;
        dp    = 4'b0000;
        load  = 1'b1;
        @(negedge clk);
        load  = 1'b0;
        check("load_on_boundary", {31'b0, frame_done}, 32'd1);
        push_frame(7'b0000110, 7'b0000110, 7'b0000110, 7'b0000110, 4'b0000, 4'b0000);
        wait_frame();
        push_frame(7'b1110001, 7'b1111001, 7'b1111001, 7'b1111100, 4'b0000, 4'b0000);

        // Two loads in one frame: last one wins.
        repeat (4) @(negedge clk);
        do_load(16'h5678, 4'b0000);
        repeat (3) @(negedge clk);
        do_load(16'h9ABC, 4'b0001);
        wait_frame();
        push_frame(7'b0111001, 7'b1111100, 7'b1110111, 7'b1101111, 4'b0000, 4'b0001);

        // Long run: guard windows, one-hot-low enables and frame pulses.
        repeat (1000 * FRAME) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/led7_scan_driver.md
Name: led7_scan_driver

Overview:
- Time-multiplexed driver for a DIGITS-wide common-anode 7-segment display.
- Holds a tear-free shadow copy of a packed hex word and scans one digit per slot.
- Adds decimal points, leading-zero blanking and an anti-ghosting guard interval, all active-low at the pins.
- Sits between the datapath (counters, scores, clock values) and the board display pins.

Parameters:
- DIGITS, 4: number of display digits; digit 0 is least significant and rightmost. Legal range 2..8.
- SCAN_DIV, 50000: clock cycles per digit slot. Must be at least GUARD+2.
- GUARD, 2: cycles at the start of each slot with all digit enables off.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-high reset
- value  in  4*DIGITS  packed nibbles; nibble i occupies bits [4i+3:4i] and belongs to digit i
- dp  in  DIGITS  decimal point request per digit, 1 = lit
- lz_en  in  1  leading-zero suppression enable, sampled live
- load  in  1  single-cycle strobe that captures value and dp into the staging register
- seg_n  out  7  segments a..g on bits 0..6, active low
- dp_n  out  1  decimal point, active low
- dig_n  out  DIGITS  digit enables, active low, one-hot-low or all ones
- frame_done  out  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset, asynchronous active-high, clk and rst only:
  - seg_n=7'h7F, dp_n=1, dig_n all ones, frame_done=0.
  - Prescaler, digit index, staging, shadow and pending flag all cleared.
  - Reset mid-scan blanks the outputs immediately and scanning restarts at digit 0, cycle 0.
- Prescaler and digit index:
  - Prescaler pc counts 0..SCAN_DIV-1.
  - On wrap, digit index di advances 0..DIGITS-1 and wraps to 0.
- Frame boundary: the cycle where pc=SCAN_DIV-1 and di=DIGITS-1.
  - frame_done is registered, so it is high on the following cycle for exactly one cycle.
- load handshake:
  - load=1 writes value and dp into staging and sets pending.
  - A repeated load before the boundary overwrites staging; last one wins.
  - At a frame boundary with pending=1, shadow <= staging and pending clears.
  - If load coincides with a boundary, the transfer uses the pre-load staging. The new data stays pending until the next boundary.
  - The display never shows a mix of old and new digits within one frame.
- Glyphs, active-high before inversion, bits g..a:
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - seg_n is the bitwise inverse.
- Leading-zero suppression, lz_en=1:
  - Digit i is blanked if i>0 and shadow nibbles i..DIGITS-1 are all zero.
  - Digit 0 is never blanked, so an all-zero value shows "0".
  - Blanked digit: seg_n=7'h7F, dp_n still follows dp[i].
- Outputs are registered, with one cycle latency from (pc, di, shadow):
  - pc<GUARD: dig_n all ones, seg_n=7'h7F, dp_n=1.
  - Otherwise: dig_n has bit di low, seg_n shows the glyph or blank of nibble di, dp_n = ~dp_shadow[di].
- Width rules: pc is clog2(SCAN_DIV) bits and di is clog2(DIGITS) bits. There are no out-of-range index states.

Decomposition:
- Shared package led7_pkg holds:
  - the 16-entry glyph constant table
  - SEG_BLANK = 7'h7F
  - segment bit-index constants A..G
- One sub-module, led7_glyph: pure combinational nibble to 7-bit active-high glyph. It replaces the older single-digit decoder and is reused by other display blocks.
- Scan FSM, load handshake and suppression stay in led7_scan_driver.

Test Plan (DIGITS=4, SCAN_DIV=8, GUARD=2):
- Assert rst mid-slot with digit 2 lit -> dig_n=4'hF and seg_n=7'h7F the same cycle. After release, the first lit digit is digit 0, at cycle 3 after reset release.
- load value=16'h12AF, dp=4'b0100 -> after the next frame boundary, slots show seg_n digit0=~1110001, digit1=~1110111, digit2=~1011011 with dp_n=0, digit3=~0000110. frame_done pulses once every 32 cycles.
- Mid-frame load of 16'h0000 while 16'h1234 is displayed -> remaining digits of the current frame still show 1234; zeros appear only from the next frame.
- lz_en=1, load 16'h0050 -> digits 3 and 2 have seg_n=7'h7F, digit 1 shows ~1101101, digit 0 shows ~0111111. value=0 -> only digit 0 shows "0".
- load on the exact boundary cycle with 16'hBEEF, display previously 16'h1111 -> the next frame still shows 1111 and the frame after shows bEEF. Two loads in one frame -> only the second is shown.
- Guard check: in every slot, dig_n=all ones for cycles pc=0,1 (outputs one cycle delayed). dig_n is never multi-hot across 1000 frames.
